// File: rtl/ysyx_220053_div32_if.sv
// Operand/result handshake bundle for the 32-bit divider.
// The master side issues operands and consumes results; the slave side is the divider.
interface ysyx_220053_div32_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] dividend;
   logic [XLEN-1:0] divisor;
   logic            is_signed;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] quotient;
   logic [XLEN-1:0] remainder;

   modport master (
      output flush, in_valid, dividend, divisor, is_signed, out_ready,
      input  in_ready, out_valid, quotient, remainder
   );

   modport slave (
      input  flush, in_valid, dividend, divisor, is_signed, out_ready,
      output in_ready, out_valid, quotient, remainder
   );
endinterface

// File: rtl/ysyx_220053_div32.sv
// Restoring radix-2 divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define YSYX_220053_DIV_FASTPATH_EN to resolve divide-by-zero, overflow and small-dividend at accept.
module ysyx_220053_div32 #(
   parameter int XLEN = 32
) (
   input logic                  clk,
   input logic                  rst_n,
   ysyx_220053_div32_if.slave   io
);
   localparam int CW = $clog2(XLEN + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic            q_neg_q, q_neg_d;
   logic            r_neg_q, r_neg_d;
   logic [XLEN-1:0] quotient_q, quotient_d;
   logic [XLEN-1:0] remainder_q, remainder_d;

   logic [XLEN-1:0] abs_a, abs_b;
   logic [XLEN:0]   rem_shift, diff;
   logic            q_bit;
   logic [XLEN-1:0] rem_next, quot_next;

`ifdef YSYX_220053_DIV_FASTPATH_EN
   logic div_zero, ovf, small;
   assign div_zero = (io.divisor == '0);
   assign ovf      = io.is_signed && (io.dividend == {1'b1, {(XLEN-1){1'b0}}}) && (io.divisor == '1);
   assign small    = (abs_a < abs_b);
`endif

   // a_q doubles as the dividend shifter and the quotient accumulator
   always_comb begin
      abs_a     = (io.is_signed && io.dividend[XLEN-1]) ? -io.dividend : io.dividend;
      abs_b     = (io.is_signed && io.divisor[XLEN-1])  ? -io.divisor  : io.divisor;
      rem_shift = {rem_q, a_q[XLEN-1]};
      diff      = rem_shift - {1'b0, b_q};
      q_bit     = ~diff[XLEN];
      rem_next  = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
      quot_next = {a_q[XLEN-2:0], q_bit};
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      rem_d       = rem_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      if (io.flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (io.in_valid) begin
                  a_d     = abs_a;
                  b_d     = abs_b;
                  rem_d   = '0;
                  cnt_d   = CW'(XLEN);
                  // zero divisor keeps the all-ones quotient unsigned in sign
                  q_neg_d = io.is_signed && (io.dividend[XLEN-1] ^ io.divisor[XLEN-1])
                            && (io.divisor != '0);
                  r_neg_d = io.is_signed && io.dividend[XLEN-1];
                  state_d = S_BUSY;
`ifdef YSYX_220053_DIV_FASTPATH_EN
                  if (div_zero) begin
                     quotient_d  = '1;
                     remainder_d = io.dividend;
                     state_d     = S_DONE;
                  end else if (ovf) begin
                     quotient_d  = {1'b1, {(XLEN-1){1'b0}}};
                     remainder_d = '0;
                     state_d     = S_DONE;
                  end else if (small) begin
                     quotient_d  = '0;
                     remainder_d = io.dividend;
                     state_d     = S_DONE;
                  end
`endif
               end
            end
            S_BUSY: begin
               a_d   = quot_next;
               rem_d = rem_next;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  quotient_d  = q_neg_q ? -quot_next : quot_next;
                  remainder_d = r_neg_q ? -rem_next  : rem_next;
                  state_d     = S_DONE;
               end
            end
            S_DONE: begin
               if (io.out_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rem_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rem_q       <= rem_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign io.in_ready  = (state_q == S_IDLE);
   assign io.out_valid = (state_q == S_DONE);
   assign io.quotient  = quotient_q;
   assign io.remainder = remainder_q;
endmodule

// File: tb/tb_ysyx_220053_div32.sv
// Scoreboard bench for the 32-bit divider: directed vectors push expected results,
// a monitor pops and compares on every accepted output.
module tb_ysyx_220053_div32;
   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      int          id;
   } exp_t;

`ifdef YSYX_220053_DIV_FASTPATH_EN
   localparam int FAST_LAT = 0;
`else
   localparam int FAST_LAT = 32;
`endif
   localparam int SLOW_LAT = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   ysyx_220053_div32_if #(.XLEN(32)) io ();

   ysyx_220053_div32 #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
      end
   endtask

   // Issues one operation; returns #1 after the accepting edge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                input logic [31:0] eq, input logic [31:0] er, input int id,
                                input bit push);
      exp_t e;
      int   w = 0;
      while (!io.in_ready && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      io.dividend  = a;
      io.divisor   = b;
      io.is_signed = s;
      io.in_valid  = 1'b1;
      if (push) begin
         e.q = eq; e.r = er; e.id = id;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      io.in_valid  = 1'b0;
      io.dividend  = 32'hA5A5_A5A5;
      io.divisor   = 32'h5A5A_5A5A;
      io.is_signed = ~s;
   endtask

   // Edges after the accepting edge until out_valid is observed.
   task automatic waitResult(input int elat);
      int lat = 0;
      while (!io.out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("latency", 32'(lat), 32'(elat));
      if (io.out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic watchSilent(input string nm);
      bit seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (io.out_valid) seen = 1'b1;
      end
      checkOutput(nm, 32'(seen), 32'd0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && io.out_valid && io.out_ready) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_result: got q=0x%08h r=0x%08h expected no output",
                        io.quotient, io.remainder);
            end else begin
               e = sb.pop_front();
               checkOutput($sformatf("quotient#%0d", e.id), io.quotient, e.q);
               checkOutput($sformatf("remainder#%0d", e.id), io.remainder, e.r);
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      io.flush     = 1'b0;
      io.in_valid  = 1'b0;
      io.out_ready = 1'b1;
      io.dividend  = '0;
      io.divisor   = '0;
      io.is_signed = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", 32'(io.in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(io.out_valid), 32'd0);
      checkOutput("rst_quotient", io.quotient, 32'd0);
      checkOutput("rst_remainder", io.remainder, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed vectors: dividend, divisor, signed, quotient, remainder
      applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1, 1'b1);
      waitResult(SLOW_LAT);
      applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2, 1'b1);
      waitResult(SLOW_LAT);
      applyStimulus(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 3, 1'b1);
      waitResult(FAST_LAT);
      applyStimulus(32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 4, 1'b1);
      waitResult(FAST_LAT);
      applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 5, 1'b1);
      waitResult(FAST_LAT);
      applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 6, 1'b1);
      waitResult(FAST_LAT);
      applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 7, 1'b1);
      waitResult(SLOW_LAT);
      applyStimulus(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 8, 1'b1);
      waitResult(SLOW_LAT);
      applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 9, 1'b1);
      waitResult(SLOW_LAT);
      applyStimulus(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 10, 1'b1);
      waitResult(FAST_LAT);
      applyStimulus(32'hFFFF_FFFB, 32'd9, 1'b1, 32'd0, 32'hFFFF_FFFB, 11, 1'b1);
      waitResult(FAST_LAT);
      applyStimulus(32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 12, 1'b1);
      waitResult(SLOW_LAT);
      applyStimulus(32'd1000000, 32'd1000, 1'b1, 32'd1000, 32'd0, 13, 1'b1);
      waitResult(SLOW_LAT);
      applyStimulus(32'h8000_0000, 32'd3, 1'b1, 32'hD555_5556, 32'hFFFF_FFFE, 14, 1'b1);
      waitResult(SLOW_LAT);

      // backpressure: result must hold and no new op may be accepted
      io.out_ready = 1'b0;
      applyStimulus(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 15, 1'b1);
      waitResult(SLOW_LAT);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            io.dividend = 32'd77; io.divisor = 32'd5; io.is_signed = 1'b0; io.in_valid = 1'b1;
         end
         if (i == 6) io.in_valid = 1'b0;
         @(posedge clk); #1;
         checkOutput("hold_quotient", io.quotient, 32'd142);
         checkOutput("hold_remainder", io.remainder, 32'd6);
         checkOutput("hold_in_ready", 32'(io.in_ready), 32'd0);
         checkOutput("hold_out_valid", 32'(io.out_valid), 32'd1);
      end
      io.out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("release_in_ready", 32'(io.in_ready), 32'd1);
      checkOutput("release_out_valid", 32'(io.out_valid), 32'd0);

      // flush while IDLE with in_valid: no accept
      io.dividend = 32'd8; io.divisor = 32'd2; io.is_signed = 1'b0;
      io.in_valid = 1'b1; io.flush = 1'b1;
      @(posedge clk); #1;
      io.in_valid = 1'b0; io.flush = 1'b0;
      checkOutput("flush_idle_in_ready", 32'(io.in_ready), 32'd1);

      // flush while DONE with the consumer stalled: result dropped
      io.out_ready = 1'b0;
      applyStimulus(32'd20, 32'd4, 1'b0, 32'd5, 32'd0, 16, 1'b0);
      waitResult(SLOW_LAT);
      io.flush = 1'b1;
      @(posedge clk); #1;
      io.flush = 1'b0;
      io.out_ready = 1'b1;
      checkOutput("flush_done_out_valid", 32'(io.out_valid), 32'd0);
      checkOutput("flush_done_in_ready", 32'(io.in_ready), 32'd1);

      // flush at BUSY cycle 5: operation never completes
      applyStimulus(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 17, 1'b0);
      repeat (4) begin
         @(posedge clk); #1;
      end
      io.flush = 1'b1;
      @(posedge clk); #1;
      io.flush = 1'b0;
      checkOutput("flush_busy_in_ready", 32'(io.in_ready), 32'd1);
      checkOutput("flush_busy_out_valid", 32'(io.out_valid), 32'd0);
      watchSilent("flush_busy_silent");
      applyStimulus(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 18, 1'b1);
      waitResult(SLOW_LAT);

      // reset at BUSY cycle 20
      applyStimulus(32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 19, 1'b0);
      repeat (19) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checkOutput("midrst_out_valid", 32'(io.out_valid), 32'd0);
      checkOutput("midrst_quotient", io.quotient, 32'd0);
      checkOutput("midrst_remainder", io.remainder, 32'd0);
      checkOutput("midrst_in_ready", 32'(io.in_ready), 32'd1);
      watchSilent("midrst_silent");

      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
